// File: rtl/ocf_machine_cycle.sv
// Z80 opcode-fetch (M1) machine cycle: address/strobe sequencing, wait-state
// handling, opcode capture and the refresh half-cycle, driven by the decoder.
module ocf_machine_cycle #(
  parameter int          EXTRA_WAIT = 0,
  parameter logic [7:0]  RST_OPCODE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        OCF_start,
  input  logic [15:0] PC,
  input  logic [15:0] IR,
  input  logic        WAIT_L,
  input  logic [7:0]  data_in,
  output logic [7:0]  opcode,
  output logic        OCF_done,
  output logic        OCF_bus,
  output logic [15:0] addr,
  output logic        M1_L,
  output logic        MREQ_L,
  output logic        RD_L,
  output logic        RFSH_L,
  output logic        R_inc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_T1,
    S_T2,
    S_TW,
    S_T3,
    S_T4
  } state_t;

  localparam logic [7:0] EXTRA_W = 8'(EXTRA_WAIT);

  state_t      state_reg;
  logic [15:0] addr_reg;
  logic [7:0]  opcode_reg;
  logic [7:0]  wait_cnt_reg;
  logic        stall;

  // Forced waits come first; WAIT_L can stretch the read phase indefinitely.
  assign stall = (wait_cnt_reg < EXTRA_W) || !WAIT_L;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_reg    <= S_IDLE;
      addr_reg     <= 16'h0000;
      opcode_reg   <= RST_OPCODE;
      wait_cnt_reg <= 8'h00;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (OCF_start) begin
            state_reg <= S_T1;
            addr_reg  <= PC;
          end
        end
        S_T1: state_reg <= S_T2;
        S_T2, S_TW: begin
          if (stall) begin
            state_reg <= S_TW;
            if (wait_cnt_reg != 8'hFF) wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end else begin
            state_reg    <= S_T3;
            opcode_reg   <= data_in;
            addr_reg     <= IR;
            wait_cnt_reg <= 8'h00;
          end
        end
        S_T3: state_reg <= S_T4;
        S_T4: begin
          // Back-to-back fetch skips IDLE entirely.
          if (OCF_start) begin
            state_reg <= S_T1;
            addr_reg  <= PC;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, never directly on inputs.
  logic read_phase;
  logic rfsh_phase;

  assign read_phase = (state_reg == S_T1) || (state_reg == S_T2) || (state_reg == S_TW);
  assign rfsh_phase = (state_reg == S_T3) || (state_reg == S_T4);

  assign opcode   = opcode_reg;
  assign addr     = addr_reg;
  assign OCF_bus  = (state_reg != S_IDLE);
  assign OCF_done = (state_reg == S_T4);
  assign R_inc    = (state_reg == S_T4);
  assign M1_L     = !read_phase;
  assign RD_L     = !read_phase;
  assign MREQ_L   = !(read_phase || (state_reg == S_T3));
  assign RFSH_L   = !rfsh_phase;

endmodule
